// File: rtl/disp_pkg.sv
// Shared display-path definitions: read-controller states, fixed AXI read
// attributes and the 64-bit beat to 24-bit pixel packing.
package disp_pkg;

  typedef enum logic [2:0] {IDLE, CLR, WAIT, ADDR, DATA} disp_state_e;

  localparam logic [2:0] AXI_ARSIZE     = 3'b011;  // 8 bytes per beat
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  // Two pixels per beat, each in the low 24 bits of a 32-bit half.
  localparam int PIX_W        = 24;
  localparam int PIX_PER_BEAT = 2;
  localparam int PIX0_LSB     = 0;
  localparam int PIX1_LSB     = 32;

  typedef logic [PIX_W-1:0] pixel_t;

  function automatic pixel_t beat_pixel(input logic [63:0] beat, input logic idx);
    return idx ? beat[PIX1_LSB +: PIX_W] : beat[PIX0_LSB +: PIX_W];
  endfunction

endpackage

// File: rtl/disp_vram_rdctrl_if.sv
// AXI4 read-address / read-data channels between the frame-buffer reader
// (master) and the VRAM interconnect (slave).
interface disp_vram_rdctrl_if;
  logic [31:0] ARADDR;
  logic [7:0]  ARLEN;
  logic [2:0]  ARSIZE;
  logic [1:0]  ARBURST;
  logic        ARVALID;
  logic        ARREADY;
  logic [63:0] RDATA;
  logic        RLAST;
  logic        RVALID;
  logic        RREADY;

  modport master (
    output ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
    input  ARREADY, RDATA, RLAST, RVALID
  );

  modport slave (
    input  ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
    output ARREADY, RDATA, RLAST, RVALID
  );
endinterface

// File: rtl/disp_burst_cnt.sv
// Burst address register and remaining-burst counter for one frame fetch.
module disp_burst_cnt
  import disp_pkg::*;
#(
  parameter int NBURST      = 9600,
  parameter int BURST_BYTES = 128,
  parameter int CNT_W       = 14
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        dec,
  input  logic [31:0] base,
  output logic [31:0] addr,
  output logic        zero
);

  logic [31:0]      addr_d, addr_q;
  logic [CNT_W-1:0] rem_d, rem_q;

  // Base is forced onto a burst boundary; load wins over decrement.
  always_comb begin
    addr_d = addr_q;
    rem_d  = rem_q;
    if (load) begin
      addr_d = base & ~32'(BURST_BYTES - 1);
      rem_d  = CNT_W'(NBURST);
    end else if (dec) begin
      addr_d = addr_q + 32'(BURST_BYTES);
      rem_d  = rem_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      rem_q  <= '0;
    end else begin
      addr_q <= addr_d;
      rem_q  <= rem_d;
    end
  end

  assign addr = addr_q;
  assign zero = (rem_q == '0);

endmodule

// File: rtl/disp_vram_rdctrl.sv
// Frame-buffer read controller: per frame, clear the display FIFO, then pull
// the frame from VRAM in fixed AXI4 bursts gated by FIFO room.
module disp_vram_rdctrl
  import disp_pkg::*;
#(
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int BURST_LEN  = 16,
  parameter int RST_CYCLES = 8
) (
  input  logic                      ACLK,
  input  logic                      ARST,
  input  logic                      DISPON,
  input  logic [31:0]               DISPADDR,
  input  logic                      FRAME_START,
  input  logic                      BUF_WREADY,
  disp_vram_rdctrl_if.master        axi,
  output logic                      FIFORST,
  output logic [63:0]               FIFOIN,
  output logic                      FIFOWR,
  output logic                      FRAME_LATE
);

  // H_RES*V_RES must be a multiple of 2*BURST_LEN.
  localparam int NBURST      = H_RES * V_RES / (2 * BURST_LEN);
  localparam int CNT_W       = $clog2(NBURST + 1);
  localparam int BURST_BYTES = BURST_LEN * 8;
  localparam int CLR_W       = (2 * RST_CYCLES > 1) ? $clog2(2 * RST_CYCLES) : 1;
  localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(2 * RST_CYCLES - 1);

  disp_state_e      state_d, state_q;
  logic [CLR_W-1:0] clr_cnt_d, clr_cnt_q;
  logic             fiforst_d, fiforst_q;
  logic             arvalid_d, arvalid_q;
  logic             rready_d, rready_q;
  logic             late_d, late_q;
  logic             pend_d, pend_q;
  logic             pend_on_d, pend_on_q;
  logic             fifowr_d, fifowr_q;
  logic [63:0]      fifoin_d, fifoin_q;
  logic             cnt_ld, cnt_dec, restart, beat, rem_zero;
  logic [31:0]      cur_addr;

  disp_burst_cnt #(
    .NBURST      (NBURST),
    .BURST_BYTES (BURST_BYTES),
    .CNT_W       (CNT_W)
  ) u_cnt (
    .clk  (ACLK),
    .rst  (ARST),
    .load (cnt_ld),
    .dec  (cnt_dec),
    .base (DISPADDR),
    .addr (cur_addr),
    .zero (rem_zero)
  );

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    fiforst_d = 1'b0;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    late_d    = 1'b0;
    pend_d    = pend_q;
    pend_on_d = pend_on_q;
    cnt_ld    = 1'b0;
    cnt_dec   = 1'b0;
    restart   = 1'b0;
    beat      = axi.RVALID & rready_q;
    fifowr_d  = beat;
    fifoin_d  = beat ? axi.RDATA : fifoin_q;

    unique case (state_q)
      IDLE: restart = FRAME_START & DISPON;
      CLR, WAIT: begin
        if (state_q == CLR) begin
          // FIFORST for the first RST_CYCLES, then an equal quiet period.
          clr_cnt_d = clr_cnt_q + 1'b1;
          fiforst_d = (int'(clr_cnt_q) + 1) < RST_CYCLES;
          if (clr_cnt_q == CLR_LAST) state_d = WAIT;
        end else if (rem_zero) begin
          state_d = IDLE;
        end else if (BUF_WREADY) begin
          state_d   = ADDR;
          arvalid_d = 1'b1;
        end
        if (FRAME_START) begin
          late_d    = ~rem_zero;
          arvalid_d = 1'b0;
          fiforst_d = 1'b0;
          state_d   = IDLE;
          restart   = DISPON;
        end
      end
      ADDR, DATA: begin
        // A burst in flight always completes; the new frame waits for RLAST.
        if (FRAME_START) begin
          late_d    = 1'b1;
          pend_d    = 1'b1;
          pend_on_d = DISPON;
        end
        if (state_q == ADDR) begin
          if (axi.ARREADY) begin
            arvalid_d = 1'b0;
            rready_d  = 1'b1;
            state_d   = DATA;
          end
        end else if (beat & axi.RLAST) begin
          rready_d = 1'b0;
          if (pend_d) begin
            pend_d  = 1'b0;
            state_d = IDLE;
            restart = pend_on_d;
          end else begin
            cnt_dec = 1'b1;
            state_d = WAIT;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (restart) begin
      cnt_ld    = 1'b1;
      state_d   = CLR;
      clr_cnt_d = '0;
      fiforst_d = 1'b1;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARST) begin
      state_q   <= IDLE;
      clr_cnt_q <= '0;
      fiforst_q <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      late_q    <= 1'b0;
      pend_q    <= 1'b0;
      pend_on_q <= 1'b0;
      fifowr_q  <= 1'b0;
      fifoin_q  <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      fiforst_q <= fiforst_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      late_q    <= late_d;
      pend_q    <= pend_d;
      pend_on_q <= pend_on_d;
      fifowr_q  <= fifowr_d;
      fifoin_q  <= fifoin_d;
    end
  end

  assign axi.ARADDR  = cur_addr;
  assign axi.ARLEN   = 8'(BURST_LEN - 1);
  assign axi.ARSIZE  = AXI_ARSIZE;
  assign axi.ARBURST = AXI_BURST_INCR;
  assign axi.ARVALID = arvalid_q;
  assign axi.RREADY  = rready_q;
  assign FIFORST     = fiforst_q;
  assign FIFOIN      = fifoin_q;
  assign FIFOWR      = fifowr_q;
  assign FRAME_LATE  = late_q;

endmodule

// File: tb/tb_disp_vram_rdctrl.sv
// Directed bench for disp_vram_rdctrl on a 64x2 frame (4 bursts of 16 beats).
module tb_disp_vram_rdctrl;
  import disp_pkg::*;

  localparam int BL = 16;

  logic        clk;
  logic        ARST = 1'b1, DISPON = 1'b0, FRAME_START = 1'b0, BUF_WREADY = 1'b0;
  logic [31:0] DISPADDR = '0;
  logic        FIFORST, FIFOWR, FRAME_LATE;
  logic [63:0] FIFOIN;

  disp_vram_rdctrl_if axi();

  disp_vram_rdctrl #(
    .H_RES(64), .V_RES(2), .BURST_LEN(BL), .RST_CYCLES(8)
  ) dut (
    .ACLK        (clk),
    .ARST        (ARST),
    .DISPON      (DISPON),
    .DISPADDR    (DISPADDR),
    .FRAME_START (FRAME_START),
    .BUF_WREADY  (BUF_WREADY),
    .axi         (axi),
    .FIFORST     (FIFORST),
    .FIFOIN      (FIFOIN),
    .FIFOWR      (FIFOWR),
    .FRAME_LATE  (FRAME_LATE)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_tests = 0, n_fail = 0, cyc = 0;
  int ar_delay = 0;
  bit r_gap = 1'b0;
  int wr_cnt = 0, rst_cnt = 0, late_cnt = 0, order_err = 0, ar_unstable = 0, arlen_bad = 0;
  logic [31:0] ar_addr[$];
  int          ar_cyc[$];
  int          data_seq = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] pat(input int k);
    logic [15:0] s;
    s = 16'(k);
    return {16'hC0DE, s, 16'hBEEF, s};
  endfunction

  // VRAM slave: optional ARREADY delay, optional every-other-cycle RVALID gaps.
  int s_beats = 0, s_arw = 0;
  bit s_gap = 1'b0, s_pv_ar = 1'b0, s_pv_r = 1'b0;
  initial begin
    axi.ARREADY = 1'b0; axi.RVALID = 1'b0; axi.RLAST = 1'b0; axi.RDATA = '0;
    forever begin
      @(negedge clk);
      if (ARST) begin
        axi.ARREADY = 1'b0; axi.RVALID = 1'b0; axi.RLAST = 1'b0;
        s_beats = 0; s_arw = 0; s_gap = 1'b0; s_pv_ar = 1'b0; s_pv_r = 1'b0; data_seq = 0;
      end else begin
        if (s_pv_ar && axi.ARREADY) begin s_beats = BL; s_arw = 0; end
        if (s_pv_r && axi.RVALID) begin s_beats--; data_seq++; end
        axi.ARREADY = 1'b0;
        if (axi.ARVALID && s_beats == 0) begin
          if (s_arw >= ar_delay) axi.ARREADY = 1'b1;
          else s_arw++;
        end
        s_gap = (s_beats > 0 && r_gap) ? ~s_gap : 1'b0;
        axi.RVALID = (s_beats > 0) && !s_gap;
        axi.RLAST  = axi.RVALID && (s_beats == 1);
        axi.RDATA  = pat(data_seq);
        s_pv_ar = axi.ARVALID;
        s_pv_r  = axi.RREADY;
      end
    end
  end

  // Output monitor
  logic        m_pv_arv = 1'b0;
  logic [31:0] m_pv_addr = '0;
  initial forever begin
    @(negedge clk);
    if (!ARST) begin
      if (FIFOWR) begin
        if (FIFOIN !== pat(wr_cnt)) order_err++;
        wr_cnt++;
      end
      if (FIFORST) rst_cnt++;
      if (FRAME_LATE) late_cnt++;
      if (axi.ARVALID && !m_pv_arv) begin ar_addr.push_back(axi.ARADDR); ar_cyc.push_back(cyc); end
      if (axi.ARVALID && m_pv_arv && axi.ARADDR !== m_pv_addr) ar_unstable++;
      if (axi.ARVALID && axi.ARLEN !== 8'd15) arlen_bad++;
    end
    m_pv_arv  = axi.ARVALID;
    m_pv_addr = axi.ARADDR;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    ARST = 1'b1; FRAME_START = 1'b0;
    @(negedge clk);
    wr_cnt = 0; rst_cnt = 0; late_cnt = 0; order_err = 0; ar_unstable = 0; arlen_bad = 0;
    ar_addr.delete(); ar_cyc.delete();
    @(negedge clk);
    ARST = 1'b0;
  endtask

  task automatic pulse_fs(input logic on, input logic [31:0] a, output int fc);
    DISPON = on; DISPADDR = a; FRAME_START = 1'b1;
    fc = cyc + 1;
    @(negedge clk);
    FRAME_START = 1'b0;
  endtask

  task automatic wait_ar(input int n, input string tag);
    int k = 0;
    while (ar_addr.size() < n && k < 2000) begin @(negedge clk); k++; end
    chk({"to_", tag}, 64'(k >= 2000), 64'(0));
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (dut.state_q != IDLE && k < 3000) begin @(negedge clk); k++; end
    chk({"to_", tag}, 64'(k >= 3000), 64'(0));
    tick(2);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int fc, rc, k;

    // Reset values and a clean frame fetch
    do_reset();
    chk("rst_arvalid", 64'(axi.ARVALID), 64'(0));
    chk("rst_rready",  64'(axi.RREADY),  64'(0));
    chk("rst_fifowr",  64'(FIFOWR),      64'(0));
    chk("rst_fiforst", 64'(FIFORST),     64'(0));
    chk("rst_late",    64'(FRAME_LATE),  64'(0));
    chk("rst_araddr",  64'(axi.ARADDR),  64'(0));
    chk("rst_fifoin",  FIFOIN,           64'(0));
    chk("rst_state",   64'(dut.state_q), 64'(IDLE));
    BUF_WREADY = 1'b1;
    pulse_fs(1'b1, 32'h1000_0040, fc);
    chk("fiforst_rise", 64'(FIFORST), 64'(1));
    wait_idle("frame");
    chk("f_rst_cycles", 64'(rst_cnt), 64'(8));
    chk("f_nbursts",    64'(ar_addr.size()), 64'(4));
    if (ar_addr.size() == 4) begin
      chk("f_addr0", 64'(ar_addr[0]), 64'h1000_0000);
      chk("f_addr1", 64'(ar_addr[1]), 64'h1000_0080);
      chk("f_addr2", 64'(ar_addr[2]), 64'h1000_0100);
      chk("f_addr3", 64'(ar_addr[3]), 64'h1000_0180);
      chk("f_first_ar_lat", 64'(ar_cyc[0] - fc), 64'(17));
    end
    chk("f_arlen",  64'(arlen_bad), 64'(0));
    chk("f_wr_cnt", 64'(wr_cnt),    64'(64));
    chk("f_order",  64'(order_err), 64'(0));
    chk("f_late",   64'(late_cnt),  64'(0));

    // FIFO backpressure after the second burst
    do_reset();
    BUF_WREADY = 1'b1;
    pulse_fs(1'b1, 32'h1000_0000, fc);
    wait_ar(2, "bp_ar2");
    BUF_WREADY = 1'b0;
    tick(40);
    chk("bp_hold", 64'(ar_addr.size()), 64'(2));
    rc = cyc;
    BUF_WREADY = 1'b1;
    wait_ar(3, "bp_ar3");
    if (ar_addr.size() >= 3) begin
      chk("bp_ar_lat", 64'(ar_cyc[2] - rc), 64'(1));
      chk("bp_addr2",  64'(ar_addr[2]), 64'h1000_0100);
    end
    wait_idle("bp");
    chk("bp_wr_cnt", 64'(wr_cnt), 64'(64));

    // Slow ARREADY and gapped read data
    do_reset();
    ar_delay = 5; r_gap = 1'b1;
    pulse_fs(1'b1, 32'h1000_0000, fc);
    wait_idle("slow");
    chk("slow_ar_stable", 64'(ar_unstable), 64'(0));
    chk("slow_nbursts",   64'(ar_addr.size()), 64'(4));
    chk("slow_wr_cnt",    64'(wr_cnt), 64'(64));
    chk("slow_order",     64'(order_err), 64'(0));
    ar_delay = 0; r_gap = 1'b0;

    // New frame arriving in the middle of burst 2
    do_reset();
    pulse_fs(1'b1, 32'h1000_0000, fc);
    wait_ar(2, "late_ar2");
    tick(6);
    pulse_fs(1'b1, 32'h2000_0100, fc);
    tick(1);
    chk("late_pulse", 64'(late_cnt), 64'(1));
    k = 0;
    while (!FIFORST && k < 100) begin @(negedge clk); k++; end
    chk("to_late_clr", 64'(k >= 100), 64'(0));
    tick(1);
    chk("late_burst_done", 64'(wr_cnt), 64'(32));
    wait_idle("late");
    chk("late_nbursts", 64'(ar_addr.size()), 64'(6));
    if (ar_addr.size() == 6) begin
      chk("late_new_base", 64'(ar_addr[2]), 64'h2000_0100);
      chk("late_new_last", 64'(ar_addr[5]), 64'h2000_0280);
    end
    chk("late_rst_cycles", 64'(rst_cnt), 64'(16));
    chk("late_once", 64'(late_cnt), 64'(1));

    // Display disabled at frame start
    do_reset();
    pulse_fs(1'b0, 32'h3000_0000, fc);
    tick(30);
    chk("off_fiforst", 64'(rst_cnt), 64'(0));
    chk("off_no_ar",   64'(ar_addr.size()), 64'(0));
    chk("off_no_late", 64'(late_cnt), 64'(0));
    chk("off_idle",    64'(dut.state_q), 64'(IDLE));
    BUF_WREADY = 1'b0;
    pulse_fs(1'b1, 32'h3000_0000, fc);
    tick(25);
    chk("stall_wait", 64'(dut.state_q), 64'(WAIT));
    pulse_fs(1'b0, 32'h3000_0000, fc);
    tick(2);
    chk("off_late",     64'(late_cnt), 64'(1));
    chk("off_idle2",    64'(dut.state_q), 64'(IDLE));
    chk("off_no_ar2",   64'(ar_addr.size()), 64'(0));
    chk("off_rst_cyc",  64'(rst_cnt), 64'(8));

    // Reset in the middle of a data burst
    do_reset();
    BUF_WREADY = 1'b1;
    pulse_fs(1'b1, 32'h1000_0000, fc);
    wait_ar(1, "arst_ar1");
    tick(5);
    chk("arst_pre_rready", 64'(axi.RREADY), 64'(1));
    chk("arst_pre_fifowr", 64'(FIFOWR), 64'(1));
    ARST = 1'b1;
    @(negedge clk);
    chk("arst_rready",  64'(axi.RREADY),  64'(0));
    chk("arst_fifowr",  64'(FIFOWR),      64'(0));
    chk("arst_arvalid", 64'(axi.ARVALID), 64'(0));
    chk("arst_araddr",  64'(axi.ARADDR),  64'(0));
    chk("arst_state",   64'(dut.state_q), 64'(IDLE));
    ARST = 1'b0;
    tick(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
